mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have a single clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- md_start, in, 1: start request; sampled only when idle.
- md_op, in, 2: operation; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_op_x, in, 32: rs operand (multiplicand or dividend).
- md_op_y, in, 32: rt operand (multiplier or divisor).
- md_flush, in, 1: cancels the in-flight operation.
- hilo_we_hi, in, 1: MTHI write enable.
- hilo_we_lo, in, 1: MTLO write enable.
- hilo_wdata, in, 32: MTHI/MTLO data.
- md_busy, out, 1: operation in flight; the pipeline stalls MFHI/MFLO and new MULT/DIV on it.
- md_done, out, 1: one-cycle pulse when HI/LO are updated by an operation.
- hi, out, 32: HI register, fed to the ALU via the PASSX path for MFHI.
- lo, out, 32: LO register, fed to the ALU via the PASSX path for MFLO.

Function
REQ-003 The state machine SHALL have the states IDLE, RUN and FIX; md_busy SHALL be 1 in RUN and FIX, and 0 in IDLE.
REQ-004 Transitions:
- IDLE to RUN on md_start at edge E0; operands and op are latched at E0.
- RUN lasts 32 cycles (edges E1..E32), tracked by a 5-bit iteration counter counting from 31 down to 0.
- RUN to FIX after the counter reaches 0.
- FIX to IDLE at E33, writing hi/lo, with md_done=1 for the single cycle after E33.
REQ-005 Multiply SHALL be iterative shift-add on operand magnitudes, with a 64-bit product split as hi=product[63:32] and lo=product[31:0]; MULT negates the product if the operand signs differ.
REQ-006 Divide SHALL be restoring division on magnitudes with the following rules:
- lo=quotient, hi=remainder.
- DIV quotient is negative if the signs differ.
- The remainder sign follows the dividend.
REQ-007 Boundary results:
- DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
- Division by zero SHALL complete with normal latency, giving lo=0xFFFFFFFF and hi=md_op_x (DIVU) or hi=md_op_x (DIV, sign unchanged).
REQ-008 md_start while busy SHALL be ignored; the operation in flight SHALL not be disturbed.
REQ-009 MTHI/MTLO writes:
- hilo_we_hi/hilo_we_lo SHALL write hi/lo only in IDLE; they SHALL be ignored while busy.
- If md_start and a write enable are both asserted in IDLE, md_start SHALL win and the write SHALL be dropped.
REQ-010 md_flush in RUN or FIX SHALL return the FSM to IDLE at the next edge, with hi/lo unchanged and no md_done; md_flush in IDLE SHALL take priority over md_start.
REQ-011 hi/lo SHALL change only on FIX exit, on MTHI/MTLO, on the fast-multiply path (REQ-014) or on reset.

Reset
REQ-012 On rst_n=0 the block SHALL asynchronously enter IDLE with hi=0, lo=0, md_busy=0, md_done=0 and counter=0; this includes reset in the middle of an operation, where the partial result SHALL be discarded.
REQ-013 After rst_n deasserts, the first md_start SHALL be accepted on the first clock edge.

Configuration
REQ-014 Macro MD_FAST_MUL_EN:
- Defined: MULT/MULTU SHALL use a single-cycle combinational 32x32 multiplier; hi/lo are written at E0, md_done=1 after E0, and md_busy stays 0. DIV/DIVU remain iterative.
- Undefined: all operations SHALL use the 33-cycle iterative path of REQ-004.

Verification
REQ-015 DIVU x=100, y=7 -> md_busy high from E0 for 33 cycles; md_done after E33; lo=14, hi=2.
REQ-016 DIV x=-7 (0xFFFFFFF9), y=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-017 MULT x=-3, y=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1; done after 33 cycles (macro off) or 1 cycle (macro on); MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=1.
REQ-018 Start DIVU, assert md_flush at cycle 10 -> md_busy=0 next cycle, no md_done, hi/lo keep their prior values; then MTLO 0x1234 in IDLE -> lo=0x1234.
REQ-019 Start DIVU 9/0, pulse rst_n low at cycle 5 -> hi=lo=0, IDLE immediately; rerun with no reset -> lo=0xFFFFFFFF, hi=9.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, sign fix-up on exit. Optional macro MD_FAST_MUL_EN.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic [31:0] md_op_x,
  input  logic [31:0] md_op_y,
  input  logic        md_flush,
  input  logic        hilo_we_hi,
  input  logic        hilo_we_lo,
  input  logic [31:0] hilo_wdata,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] mag_b;
  logic        is_div, neg_q, neg_r, div_zero;

  logic        signed_op, x_neg, y_neg, fast_sel, start_it;
  logic [31:0] x_mag, y_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_nx, div_nx, res_mul;
  logic        div_ge;
  logic [31:0] div_diff, quot, rem, res_hi, res_lo;

  assign signed_op = ~md_op[0];
  assign x_neg     = signed_op & md_op_x[31];
  assign y_neg     = signed_op & md_op_y[31];
  assign x_mag     = x_neg ? (32'd0 - md_op_x) : md_op_x;
  assign y_mag     = y_neg ? (32'd0 - md_op_y) : md_op_y;

`ifdef MD_FAST_MUL_EN
  logic [63:0] fast_mag, fast_prod;
  assign fast_sel  = ~md_op[1];
  assign fast_mag  = {32'd0, x_mag} * {32'd0, y_mag};
  assign fast_prod = (x_neg ^ y_neg) ? (64'd0 - fast_mag) : fast_mag;
`else
  assign fast_sel  = 1'b0;
`endif

  // Flush in IDLE outranks start.
  assign start_it = md_start & ~md_flush & ~fast_sel;
  assign md_busy  = (state != S_IDLE);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
  assign mul_nx   = {mul_sum, acc[31:1]};
  assign div_ge   = acc[63:31] >= {1'b0, mag_b};
  assign div_diff = acc[62:31] - mag_b;
  assign div_nx   = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};

  assign res_mul  = neg_q ? (64'd0 - acc) : acc;
  assign quot     = div_zero ? '1 : (neg_q ? (32'd0 - acc[31:0]) : acc[31:0]);
  assign rem      = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
  assign res_hi   = is_div ? rem  : res_mul[63:32];
  assign res_lo   = is_div ? quot : res_mul[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_it) state_nx = S_RUN;
      S_RUN:   if (md_flush) state_nx = S_IDLE;
               else if (cnt == 5'd0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      md_done  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      md_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
`ifdef MD_FAST_MUL_EN
          if (md_start && !md_flush && fast_sel) begin
            hi      <= fast_prod[63:32];
            lo      <= fast_prod[31:0];
            md_done <= 1'b1;
          end else
`endif
          if (start_it) begin
            acc      <= {32'd0, md_op[1] ? x_mag : y_mag};
            mag_b    <= md_op[1] ? y_mag : x_mag;
            cnt      <= 5'd31;
            is_div   <= md_op[1];
            neg_q    <= x_neg ^ y_neg;
            neg_r    <= x_neg;
            div_zero <= (md_op_y == 32'd0);
          end else if (!md_start) begin
            if (hilo_we_hi) hi <= hilo_wdata;
            if (hilo_we_lo) lo <= hilo_wdata;
          end
        end
        S_RUN: begin
          if (!md_flush) begin
            acc <= is_div ? div_nx : mul_nx;
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
          end
        end
        S_FIX: begin
          if (!md_flush) begin
            hi      <= res_hi;
            lo      <= res_lo;
            md_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
